// File: rtl/cache_pkg.sv
// Purpose: shared types, geometry and store-merge helper for the 2-way data cache.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cache_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int SETS       = 16;
   localparam int WAYS       = 2;
   localparam int TAG_LSB    = 6;
   localparam int SET_LSB    = 2;
   localparam int SET_W      = 4;
   localparam int TAG_W      = ADDR_WIDTH - TAG_LSB;

   // Access-size codes shared with the MEM stage and data_mem port.
   localparam logic [2:0] DATA_ADDR_MODE_B  = 3'd0;
   localparam logic [2:0] DATA_ADDR_MODE_BU = 3'd1;
   localparam logic [2:0] DATA_ADDR_MODE_H  = 3'd2;
   localparam logic [2:0] DATA_ADDR_MODE_HU = 3'd3;
   localparam logic [2:0] DATA_ADDR_MODE_W  = 3'd4;

   typedef enum logic [1:0] {
      IDLE,
      RD_MISS,
      WR_THRU
   } cache_state_t;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_WIDTH-1:0] data;
   } cache_line_t;

   // Overlay LSB-aligned store data onto a cached word at the addressed byte lane(s).
   function automatic logic [DATA_WIDTH-1:0] merge_store(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] wdata,
      input logic [2:0]            mode,
      input logic [1:0]            offset
   );
      logic [DATA_WIDTH-1:0] v_res;
      v_res = old_word;
      case (mode)
         DATA_ADDR_MODE_B, DATA_ADDR_MODE_BU: v_res[{offset, 3'b000} +: 8]        = wdata[7:0];
         DATA_ADDR_MODE_H, DATA_ADDR_MODE_HU: v_res[{offset[1], 4'b0000} +: 16]   = wdata[15:0];
         default:                             v_res                               = wdata;
      endcase
      return v_res;
   endfunction

endpackage

// File: rtl/cache_lru_victim.sv
// Purpose: per-set LRU bit storage and the combinational victim-way pick.
// Latency: victim is combinational; LRU update lands on the next clock edge.
// Backpressure: none; updates whenever the strobe is high.
module cache_lru_victim
   import cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SET_W-1:0] i_set,
   input  logic             i_way,
   input  logic             i_upd,
   input  logic [WAYS-1:0]  i_valid,
   output logic             o_victim
);

   // One bit per set: the index of the least recently used way.
   logic [SETS-1:0] r_lru;

   // The way just used becomes MRU, so the other way becomes LRU.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lru <= '0;
      end else if (i_upd) begin
         r_lru[i_set] <= ~i_way;
      end
   end

   // Fill invalid ways first (way0 before way1), then fall back to the LRU way.
   always_comb begin
      if (!i_valid[0]) begin
         o_victim = 1'b0;
      end else if (!i_valid[1]) begin
         o_victim = 1'b1;
      end else begin
         o_victim = r_lru[i_set];
      end
   end

endmodule

// File: rtl/cache_ctrl.sv
// Purpose: blocking 2-way set-associative, write-through, no-write-allocate data cache controller.
// Latency: read hit returns data in the request cycle; misses and stores complete in the mem_ack cycle.
// Backpressure: cpu_stall holds the pipeline until the single outstanding memory request is acked.
module cache_ctrl
   import cache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [2:0]            cpu_addr_mode,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [2:0]            mem_addr_mode,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);

   cache_line_t           r_lines [SETS][WAYS];
   cache_state_t          r_state;
   cache_state_t          w_next_state;

   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [2:0]            r_mem_mode;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic [31:0]           r_hit_count;
   logic [31:0]           r_miss_count;

   logic [SET_W-1:0]      w_set;
   logic [TAG_W-1:0]      w_tag;
   logic [WAYS-1:0]       w_valid;
   logic [WAYS-1:0]       w_hit;
   logic                  w_any_hit;
   logic                  w_hit_way;
   logic                  w_victim;
   logic                  w_issue;
   logic                  w_done;
   logic                  w_fill;
   logic                  w_merge;
   logic                  w_lru_upd;
   logic                  w_lru_way;
   logic                  w_hit_inc;
   logic                  w_miss_inc;

   assign w_set     = cpu_addr[SET_LSB +: SET_W];
   assign w_tag     = cpu_addr[ADDR_WIDTH-1:TAG_LSB];
   assign w_any_hit = |w_hit;
   assign w_hit_way = w_hit[1];

   assign mem_req       = r_mem_req;
   assign mem_we        = r_mem_we;
   assign mem_addr_mode = r_mem_mode;
   assign mem_addr      = r_mem_addr;
   assign mem_wdata     = r_mem_wdata;
   assign hit_count     = r_hit_count;
   assign miss_count    = r_miss_count;

   // Tag compare against both ways of the addressed set.
   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         w_valid[w] = r_lines[w_set][w].valid;
         w_hit[w]   = r_lines[w_set][w].valid && (r_lines[w_set][w].tag == w_tag);
      end
   end

   a_one_hot_hit: assert property (@(posedge clk) disable iff (!rst_n) !(w_hit[0] && w_hit[1]));

   cache_lru_victim u_lru (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_set    (w_set),
      .i_way    (w_lru_way),
      .i_upd    (w_lru_upd),
      .i_valid  (w_valid),
      .o_victim (w_victim)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state, stall/read-data outputs and the update strobes for arrays, LRU and counters.
   always_comb begin
      w_next_state = r_state;
      cpu_stall    = 1'b0;
      cpu_rdata    = '0;
      w_issue      = 1'b0;
      w_done       = 1'b0;
      w_fill       = 1'b0;
      w_merge      = 1'b0;
      w_lru_upd    = 1'b0;
      w_lru_way    = w_hit_way;
      w_hit_inc    = 1'b0;
      w_miss_inc   = 1'b0;
      case (r_state)
         IDLE: begin
            if (cpu_req) begin
               if (cpu_we) begin
                  cpu_stall    = 1'b1;
                  w_issue      = 1'b1;
                  w_next_state = WR_THRU;
               end else if (w_any_hit) begin
                  cpu_rdata = r_lines[w_set][w_hit_way].data;
                  w_lru_upd = 1'b1;
                  w_hit_inc = 1'b1;
               end else begin
                  cpu_stall    = 1'b1;
                  w_issue      = 1'b1;
                  w_miss_inc   = 1'b1;
                  w_next_state = RD_MISS;
               end
            end
         end
         RD_MISS: begin
            if (mem_ack) begin
               cpu_rdata    = mem_rdata;
               w_fill       = 1'b1;
               w_lru_upd    = 1'b1;
               w_lru_way    = w_victim;
               w_done       = 1'b1;
               w_next_state = IDLE;
            end else begin
               cpu_stall = 1'b1;
            end
         end
         WR_THRU: begin
            if (mem_ack) begin
               w_done       = 1'b1;
               w_next_state = IDLE;
               if (w_any_hit) begin
                  w_merge   = 1'b1;
                  w_lru_upd = 1'b1;
               end
            end else begin
               cpu_stall = 1'b1;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Memory request: fields latch at issue and stay frozen until the ack clears the request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_mode  <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else if (w_issue) begin
         r_mem_req   <= 1'b1;
         r_mem_we    <= cpu_we;
         r_mem_mode  <= cpu_we ? cpu_addr_mode : DATA_ADDR_MODE_W;
         r_mem_addr  <= cpu_we ? cpu_addr : {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
         r_mem_wdata <= cpu_wdata;
      end else if (w_done) begin
         r_mem_req <= 1'b0;
         r_mem_we  <= 1'b0;
      end
   end

   // Line arrays: refill writes the victim way; a store that hits merges into the hit way.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               r_lines[s][w] <= '0;
            end
         end
      end else if (w_fill) begin
         r_lines[w_set][w_victim] <= '{valid: 1'b1, tag: w_tag, data: mem_rdata};
      end else if (w_merge) begin
         r_lines[w_set][w_hit_way].data <= merge_store(r_lines[w_set][w_hit_way].data,
                                                       cpu_wdata, cpu_addr_mode, cpu_addr[1:0]);
      end
   end

   // Read hit/miss statistics, free-running and wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         if (w_hit_inc) begin
            r_hit_count <= r_hit_count + 32'd1;
         end
         if (w_miss_inc) begin
            r_miss_count <= r_miss_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;
   import cache_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [2:0]  cpu_addr_mode = '0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        mem_req;
   logic        mem_we;
   logic [2:0]  mem_addr_mode;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   cache_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr_mode(cpu_addr_mode),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_mode(mem_addr_mode), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: backing memory by word address, and per set a recency-ordered list of
   // cached lines (entry 0 is most recently used, at most two entries).
   logic [31:0] mem_words [logic [31:0]];
   int          m_cnt  [16];
   logic [25:0] m_tag  [16][2];
   logic [31:0] m_data [16][2];
   logic [31:0] exp_hits   = '0;
   logic [31:0] exp_misses = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_get(input logic [31:0] wa);
      if (!mem_words.exists(wa)) mem_words[wa] = $urandom;
      return mem_words[wa];
   endfunction

   function automatic int model_find(input int s, input logic [25:0] t);
      for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) return i;
      return -1;
   endfunction

   function automatic void model_touch(input int s, input int idx);
      logic [25:0] t;
      logic [31:0] d;
      t = m_tag[s][idx];
      d = m_data[s][idx];
      for (int i = idx; i > 0; i--) begin
         m_tag[s][i]  = m_tag[s][i-1];
         m_data[s][i] = m_data[s][i-1];
      end
      m_tag[s][0]  = t;
      m_data[s][0] = d;
   endfunction

   function automatic void model_fill(input int s, input logic [25:0] t, input logic [31:0] d);
      m_tag[s][1]  = m_tag[s][0];
      m_data[s][1] = m_data[s][0];
      m_tag[s][0]  = t;
      m_data[s][0] = d;
      if (m_cnt[s] < 2) m_cnt[s]++;
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < 16; s++) m_cnt[s] = 0;
      exp_hits   = '0;
      exp_misses = '0;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [2:0] mode, input logic [31:0] addr);
      logic [7:0] b [4];
      int lane;
      for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
      lane = int'(addr % 4);
      if (mode == DATA_ADDR_MODE_B || mode == DATA_ADDR_MODE_BU) begin
         b[lane] = wd[7:0];
      end else if (mode == DATA_ADDR_MODE_H || mode == DATA_ADDR_MODE_HU) begin
         b[lane & 2]       = wd[7:0];
         b[(lane & 2) + 1] = wd[15:8];
      end else begin
         for (int i = 0; i < 4; i++) b[i] = wd[8*i +: 8];
      end
      return {b[3], b[2], b[1], b[0]};
   endfunction

   // One complete CPU access; called just after a rising edge. Acts as the memory for misses
   // and stores, acking after 'lat' waiting cycles. dut_hit reports what the DUT did.
   task automatic access(input bit we, input logic [2:0] mode, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat,
                         output bit dut_hit, output logic [31:0] got);
      int          s;
      int          idx;
      int          stalls;
      logic [25:0] t;
      logic [31:0] wa;
      logic [31:0] word;
      s      = int'(addr[5:2]);
      t      = addr[31:6];
      wa     = {addr[31:2], 2'b00};
      idx    = model_find(s, t);
      stalls = 0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr_mode = mode; cpu_addr = addr; cpu_wdata = wdata;
      @(negedge clk);
      dut_hit = !cpu_stall;
      got     = cpu_rdata;
      if (!we && idx >= 0) begin
         chk("hit_stall", cpu_stall, 0);
         chk("hit_rdata", cpu_rdata, m_data[s][idx]);
         model_touch(s, idx);
         exp_hits++;
         @(posedge clk); #1;
      end else begin
         chk("issue_stall", cpu_stall, 1);
         stalls += int'(cpu_stall);
         if (!we) exp_misses++;
         word = we ? store_merge(mem_get(wa), wdata, mode, addr) : mem_get(wa);
         @(posedge clk); #1;
         chk("mem_req_rise", mem_req, 1);
         chk("mem_we", mem_we, we);
         chk("mem_addr", mem_addr, we ? addr : wa);
         chk("mem_mode", mem_addr_mode, we ? mode : DATA_ADDR_MODE_W);
         if (we) chk("mem_wdata", mem_wdata, wdata);
         for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            stalls += int'(cpu_stall);
            chk("wait_req", mem_req, 1);
            @(posedge clk); #1;
         end
         mem_ack = 1'b1;
         mem_rdata = we ? $urandom : word;
         @(negedge clk);
         stalls += int'(cpu_stall);
         got = cpu_rdata;
         chk("stall_cycles", stalls, lat + 1);
         if (!we) chk("miss_rdata", cpu_rdata, word);
         @(posedge clk); #1;
         mem_ack = 1'b0;
         chk("mem_req_fall", mem_req, 0);
         if (we) begin
            mem_words[wa] = word;
            if (idx >= 0) begin
               m_data[s][idx] = store_merge(m_data[s][idx], wdata, mode, addr);
               model_touch(s, idx);
            end
         end else begin
            model_fill(s, t, word);
         end
      end
      cpu_req = 1'b0;
      chk("hit_count", hit_count, exp_hits);
      chk("miss_count", miss_count, exp_misses);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      bit          h;
      logic [31:0] g;
      logic [2:0]  modes [5];
      modes[0] = DATA_ADDR_MODE_B;  modes[1] = DATA_ADDR_MODE_BU; modes[2] = DATA_ADDR_MODE_H;
      modes[3] = DATA_ADDR_MODE_HU; modes[4] = DATA_ADDR_MODE_W;
      model_reset();
      mem_words[32'h140] = 32'h1122_3344;

      // Reset state.
      #3;
      chk("rst_stall", cpu_stall, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_hits", hit_count, 0);
      chk("rst_misses", miss_count, 0);
      chk("rst_rdata", cpu_rdata, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Read miss with three waiting cycles, then the same address hits.
      access(1'b0, DATA_ADDR_MODE_W, 32'h100, 32'h0, 3, h, g);
      chk("t1_miss", h, 0);
      access(1'b0, DATA_ADDR_MODE_W, 32'h100, 32'h0, 0, h, g);
      chk("t2_hit", h, 1);

      // Three lines in set 0: the LRU line (0x100) is evicted.
      access(1'b0, DATA_ADDR_MODE_W, 32'h140, 32'h0, 1, h, g);
      access(1'b0, DATA_ADDR_MODE_W, 32'h180, 32'h0, 2, h, g);
      access(1'b0, DATA_ADDR_MODE_W, 32'h100, 32'h0, 0, h, g);
      chk("t3_evicted_miss", h, 0);

      // Byte store merged into a cached line.
      access(1'b0, DATA_ADDR_MODE_W, 32'h140, 32'h0, 1, h, g);
      access(1'b1, DATA_ADDR_MODE_B, 32'h142, 32'h0000_00AB, 2, h, g);
      access(1'b0, DATA_ADDR_MODE_W, 32'h140, 32'h0, 0, h, g);
      chk("t4_hit", h, 1);
      chk("t4_merged", g, 32'h11AB_3344);

      // Store to an uncached line allocates nothing.
      access(1'b1, DATA_ADDR_MODE_W, 32'h200, 32'hCAFE_F00D, 1, h, g);
      access(1'b0, DATA_ADDR_MODE_W, 32'h200, 32'h0, 1, h, g);
      chk("t5_no_alloc", h, 0);
      chk("t5_rdata", g, 32'hCAFE_F00D);

      // Idle cycle: no stall.
      @(negedge clk);
      chk("idle_stall", cpu_stall, 0);
      @(posedge clk); #1;

      // Randomized traffic over a few conflicting sets.
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         bit          w;
         a = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         w = ($urandom_range(0, 9) < 3);
         access(w, modes[$urandom_range(0, 4)], a, $urandom, $urandom_range(0, 4), h, g);
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            chk("rand_idle_stall", cpu_stall, 0);
            @(posedge clk); #1;
         end
      end

      // Reset in the middle of a refill; the late ack must be ignored.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr_mode = DATA_ADDR_MODE_W; cpu_addr = 32'h300;
      @(posedge clk); #1;
      chk("t6_req", mem_req, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      cpu_req = 1'b0;
      #1;
      chk("t6_req_dropped", mem_req, 0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = mem_get(32'h300);
      @(negedge clk);
      chk("t6_stall", cpu_stall, 0);
      chk("t6_rdata", cpu_rdata, 0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("t6_mem_req", mem_req, 0);
      chk("t6_hits", hit_count, 0);
      chk("t6_misses", miss_count, 0);
      access(1'b0, DATA_ADDR_MODE_W, 32'h140, 32'h0, 1, h, g);
      chk("t6_invalidated", h, 0);
      access(1'b0, DATA_ADDR_MODE_W, 32'h300, 32'h0, 1, h, g);
      chk("t6_refill_dropped", h, 0);
      access(1'b0, DATA_ADDR_MODE_W, 32'h300, 32'h0, 0, h, g);
      chk("t6_refill_then_hit", h, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
